// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   INSTR_W          - instruction word width
//   RESET_PC_DEFAULT - default fetch address after reset
//   NOP_INSTR        - canonical no-op (addi x0, x0, 0), used as idle buffer contents
//   fetch_entry_t    - one buffered fetch result {instr, pc}
//   pc_plus4         - sequential successor of a word-aligned PC (wraps mod 2^32)
package fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with flush.
//   clk, reset  - clock and asynchronous active-high reset
//   flush       - discard all entries this cycle (wins over push and pop)
//   push, wdata - write one entry; accepted at full only if a pop happens in the same cycle
//   pop         - drop the head entry; ignored when empty
//   head        - current head entry (combinational read of the registered array)
//   empty       - no entries held
//   count       - number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      wdata,
  input  logic              pop,
  output fetch_entry_t      head,
  output logic              empty,
  output logic [CntW-1:0]   count
);

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A slot freed by a same-cycle pop can be refilled immediately.
  assign do_push = push && (!full || do_pop);

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{instr: NOP_INSTR, pc: 32'h0};
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage producing the PC stream and buffering in-order memory responses.
//   clk, reset                      - clock and asynchronous active-high reset
//   imem_req_valid/ready/addr       - word request to instruction memory (addr[1:0] = 0)
//   imem_rsp_valid/data             - in-order responses, never back-pressured
//   redirect_valid/pc               - taken branch/jump: flush buffer, restart at redirect_pc
//   out_valid/ready                 - buffered instruction towards decode
//   out_instr/pc/pc_plus4           - head entry; all zero while the buffer is empty
// A request is issued only when it has a guaranteed buffer slot, so responses never stall.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept; responses return in request order.
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_wdata;
  logic            fifo_push;
  logic            fifo_pop;

  logic [CntW:0]   credit_used;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_drop;
  logic [31:0]     redirect_target;
  logic            unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Every in-flight request and every buffered entry holds one slot.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < (CntW + 1)'(FIFO_DEPTH);

  assign imem_req_valid = !reset && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a redirect are stale, including one that
  // lands in the redirect cycle itself.
  assign rsp_drop   = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
  assign fifo_push  = imem_rsp_valid && !rsp_drop;
  assign fifo_wdata = '{instr: imem_rsp_data, pc: rsp_pc_q};

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready && !redirect_valid;

  assign out_instr    = fifo_empty ? 32'h0 : fifo_head.instr;
  assign out_pc       = fifo_empty ? 32'h0 : fifo_head.pc;
  assign out_pc_plus4 = fifo_empty ? 32'h0 : pc_plus4(fifo_head.pc);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
    end else if (req_fire) begin
      fetch_pc_d = pc_plus4(fetch_pc_q);
    end
  end

  always_comb begin
    rsp_pc_d = rsp_pc_q;
    if (redirect_valid) begin
      rsp_pc_d = redirect_target;
    end else if (fifo_push) begin
      rsp_pc_d = pc_plus4(rsp_pc_q);
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // No request can fire in a redirect cycle, so whatever is still in flight
      // after this cycle's response belongs to the old path.
      drop_cnt_d = outstanding_q - CntW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_plus4;

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs applied at each drive point.
  logic        k_req_ready, k_rsp_en, k_out_ready, k_redir;
  logic [31:0] k_redir_pc;

  // Reference model: memory holds requests in order, tagged with the redirect
  // epoch they were issued in; the decode-side buffer is just an occupancy
  // count plus the PC of the next instruction decode should see.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } pend_t;
  pend_t       pend[$];
  int          epoch = 0;
  int          fifo_occ;
  logic [31:0] exp_pc, exp_req;

  logic        e_req_valid, e_out_valid;
  logic [31:0] e_pc, e_instr, e_plus4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    pend.delete();
    epoch++;
    fifo_occ = 0;
    exp_pc   = RST_PC;
    exp_req  = RST_PC;
  endtask

  task automatic drive();
    imem_req_ready = k_req_ready;
    out_ready      = k_out_ready;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    imem_rsp_valid = k_rsp_en && (pend.size() > 0);
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (pend.size() > 0) imem_rsp_data = mem_word(pend[0].addr);
  endtask

  task automatic expect_now();
    e_req_valid = ((pend.size() + fifo_occ) < DEPTH) && !k_redir;
    e_out_valid = fifo_occ > 0;
    e_pc    = e_out_valid ? exp_pc : 32'h0;
    e_instr = e_out_valid ? mem_word(exp_pc) : 32'h0;
    e_plus4 = e_out_valid ? exp_pc + 32'd4 : 32'h0;
  endtask

  // Apply this cycle's events to the model, then advance to the next drive point.
  task automatic commit();
    pend_t h;
    logic  fire, pop;
    fire = e_req_valid && k_req_ready;
    pop  = e_out_valid && k_out_ready && !k_redir;
    if (imem_rsp_valid) begin
      h = pend.pop_front();
      if (!k_redir && h.epoch == epoch) fifo_occ++;
    end
    if (k_redir) begin
      epoch++;
      fifo_occ = 0;
      exp_pc   = {k_redir_pc[31:2], 2'b00};
      exp_req  = exp_pc;
    end else begin
      if (pop) begin
        fifo_occ--;
        exp_pc += 32'd4;
      end
      if (fire) begin
        pend.push_back('{addr: exp_req, epoch: epoch});
        exp_req += 32'd4;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      expect_now();
      commit();
    end
  endtask

  task automatic set_knobs(input logic rr, input logic re, input logic orr);
    k_req_ready = rr;
    k_rsp_en    = re;
    k_out_ready = orr;
    k_redir     = 1'b0;
    drive();
  endtask

  task automatic drain();
    set_knobs(1'b0, 1'b1, 1'b1);
    run_quiet(5);
  endtask

  task automatic one_redirect(input logic [31:0] target);
    k_redir    = 1'b1;
    k_redir_pc = target;
    drive();
    run_quiet(1);
    k_redir = 1'b0;
    drive();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    k_req_ready = 1'b1; k_rsp_en = 1'b0; k_out_ready = 1'b1; k_redir = 1'b0;
    k_redir_pc = 32'h0;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset.req_valid got %b exp 0", imem_req_valid);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset.out_valid got %b exp 0", out_valid);
    end
    n_checks++;
    if ({out_instr, out_pc, out_pc_plus4} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset.out_fields got %h %h %h exp 0", out_instr, out_pc, out_pc_plus4);
    end
    n_checks++;
    if (imem_req_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset.addr got %h exp %h", imem_req_addr, RST_PC);
    end
    reset = 1'b0;
    drive();
  endtask

  task automatic test_sequential();
    set_knobs(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL seq.first_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr);
    end
    expect_now();
    commit();
    repeat (12) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (imem_req_valid !== e_req_valid) begin
        n_fail++; $display("FAIL seq.req_valid got %b exp %b", imem_req_valid, e_req_valid);
      end
      if (e_req_valid) begin
        n_checks++;
        if (imem_req_addr !== exp_req) begin
          n_fail++; $display("FAIL seq.addr got %h exp %h", imem_req_addr, exp_req);
        end
      end
      n_checks++;
      if (out_valid !== e_out_valid || out_pc !== e_pc || out_pc_plus4 !== e_plus4
          || out_instr !== e_instr) begin
        n_fail++;
        $display("FAIL seq.out got v=%b pc=%h p4=%h i=%h exp v=%b pc=%h p4=%h i=%h",
                 out_valid, out_pc, out_pc_plus4, out_instr, e_out_valid, e_pc, e_plus4, e_instr);
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] base;
    logic        found;
    drain();
    base = exp_req;
    set_knobs(1'b1, 1'b1, 1'b0);
    repeat (6) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (imem_req_valid !== e_req_valid) begin
        n_fail++; $display("FAIL bp.req_valid got %b exp %b", imem_req_valid, e_req_valid);
      end
      commit();
    end
    @(negedge clk);
    expect_now();
    n_checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp.full got req_valid=%b out_valid=%b exp 0/1", imem_req_valid, out_valid);
    end
    commit();
    set_knobs(1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      expect_now();
      if (imem_req_valid) begin
        found = 1'b1;
        n_checks++;
        if (imem_req_addr !== base + 32'd4 * DEPTH) begin
          n_fail++;
          $display("FAIL bp.resume_addr got %h exp %h", imem_req_addr, base + 32'd4 * DEPTH);
        end
      end
      commit();
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL bp.resume got no request exp request within 10 cycles");
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] base;
    drain();
    base = exp_req;
    set_knobs(1'b1, 1'b0, 1'b1);
    run_quiet(1);
    set_knobs(1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== base + 32'd4) begin
        n_fail++;
        $display("FAIL stall.hold got v=%b a=%h exp v=1 a=%h", imem_req_valid, imem_req_addr,
                 base + 32'd4);
      end
      commit();
    end
  endtask

  task automatic test_redirect();
    logic found;
    drain();
    one_redirect(32'h0000_0010);
    set_knobs(1'b1, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (imem_req_valid !== e_req_valid || (e_req_valid && imem_req_addr !== exp_req)) begin
        n_fail++;
        $display("FAIL redir.pre got v=%b a=%h exp v=%b a=%h", imem_req_valid, imem_req_addr,
                 e_req_valid, exp_req);
      end
      commit();
    end
    one_redirect(32'h0000_0203);
    set_knobs(1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (out_valid !== e_out_valid || out_pc !== e_pc
          || imem_req_valid !== e_req_valid || (e_req_valid && imem_req_addr !== exp_req)) begin
        n_fail++;
        $display("FAIL redir.post got ov=%b pc=%h rv=%b a=%h exp ov=%b pc=%h rv=%b a=%h",
                 out_valid, out_pc, imem_req_valid, imem_req_addr,
                 e_out_valid, e_pc, e_req_valid, exp_req);
      end
      if (out_valid && !found) begin
        found = 1'b1;
        n_checks++;
        if (out_pc !== 32'h0000_0200) begin
          n_fail++; $display("FAIL redir.first_pc got %h exp 00000200", out_pc);
        end
      end
      commit();
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL redir.first_pc got no output exp output within 12 cycles");
    end
  endtask

  task automatic test_redirect_collision();
    drain();
    set_knobs(1'b1, 1'b0, 1'b0);
    run_quiet(3);
    set_knobs(1'b1, 1'b1, 1'b0);
    run_quiet(1);
    k_req_ready = 1'b1; k_rsp_en = 1'b1; k_out_ready = 1'b1;
    k_redir = 1'b1; k_redir_pc = 32'h0000_0400;
    drive();
    @(negedge clk);
    expect_now();
    n_checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coll.setup got rv=%b ov=%b rsp=%b exp 0/1/1", imem_req_valid, out_valid,
               imem_rsp_valid);
    end
    commit();
    set_knobs(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    expect_now();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll.flushed got out_valid=%b exp 0", out_valid);
    end
    commit();
    set_knobs(1'b1, 1'b1, 1'b1);
    repeat (6) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (out_valid !== e_out_valid || out_pc !== e_pc || out_instr !== e_instr) begin
        n_fail++;
        $display("FAIL coll.after got v=%b pc=%h i=%h exp v=%b pc=%h i=%h",
                 out_valid, out_pc, out_instr, e_out_valid, e_pc, e_instr);
      end
      commit();
    end
  endtask

  task automatic test_wrap();
    logic seen_top, seen_zero;
    drain();
    one_redirect(32'hFFFF_FFFC);
    set_knobs(1'b1, 1'b1, 1'b1);
    seen_top  = 1'b0;
    seen_zero = 1'b0;
    repeat (8) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if ((e_req_valid && imem_req_addr !== exp_req) || out_pc !== e_pc
          || out_pc_plus4 !== e_plus4) begin
        n_fail++;
        $display("FAIL wrap.step got a=%h pc=%h p4=%h exp a=%h pc=%h p4=%h",
                 imem_req_addr, out_pc, out_pc_plus4, exp_req, e_pc, e_plus4);
      end
      if (out_valid && out_pc == 32'hFFFF_FFFC) begin
        seen_top = 1'b1;
        n_checks++;
        if (out_pc_plus4 !== 32'h0) begin
          n_fail++; $display("FAIL wrap.plus4 got %h exp 00000000", out_pc_plus4);
        end
      end
      if (imem_req_valid && imem_req_addr == 32'h0) seen_zero = 1'b1;
      commit();
    end
    n_checks++;
    if (!seen_top || !seen_zero) begin
      n_fail++;
      $display("FAIL wrap.seen got top=%b zero=%b exp 1/1", seen_top, seen_zero);
    end
  endtask

  task automatic test_mid_reset();
    set_knobs(1'b1, 1'b1, 1'b0);
    run_quiet(4);
    reset = 1'b1;
    k_rsp_en = 1'b0;
    model_reset();
    drive();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL mreset.state got ov=%b rv=%b a=%h exp 0/0/%h", out_valid, imem_req_valid,
               imem_req_addr, RST_PC);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_knobs(1'b1, 1'b1, 1'b1);
    repeat (6) begin
      @(negedge clk);
      expect_now();
      n_checks++;
      if (imem_req_valid !== e_req_valid || (e_req_valid && imem_req_addr !== exp_req)
          || out_pc !== e_pc) begin
        n_fail++;
        $display("FAIL mreset.after got rv=%b a=%h pc=%h exp rv=%b a=%h pc=%h",
                 imem_req_valid, imem_req_addr, out_pc, e_req_valid, exp_req, e_pc);
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      k_req_ready = ($urandom % 4) != 0;
      k_rsp_en    = ($urandom % 3) != 0;
      k_out_ready = ($urandom % 3) != 0;
      k_redir     = ($urandom % 16) == 0;
      k_redir_pc  = $urandom;
      drive();
      @(negedge clk);
      expect_now();
      n_checks++;
      if (imem_req_valid !== e_req_valid || (e_req_valid && imem_req_addr !== exp_req)) begin
        n_fail++;
        $display("FAIL rand.req got v=%b a=%h exp v=%b a=%h", imem_req_valid, imem_req_addr,
                 e_req_valid, exp_req);
      end
      n_checks++;
      if (out_valid !== e_out_valid || out_pc !== e_pc || out_pc_plus4 !== e_plus4
          || out_instr !== e_instr) begin
        n_fail++;
        $display("FAIL rand.out got v=%b pc=%h p4=%h i=%h exp v=%b pc=%h p4=%h i=%h",
                 out_valid, out_pc, out_pc_plus4, out_instr, e_out_valid, e_pc, e_plus4, e_instr);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_req_stall();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
